// File: rtl/mist_spi_host.sv
`default_nettype none
// ============================================================================
// Module : mist_spi_host
// Brief  : SPI initiator for the MiST IO-controller link. Each frame carries
//          one command byte plus cmd_len payload bytes under one ss assertion.
//          Build macro MIST_SPI_HOST_RX_EN enables capture of sdo into rx_data.
// Rev    : 1.0  initial release
// ============================================================================
module mist_spi_host #(
    parameter int HALF_DIV = 2,
    parameter int GAP      = 8,
    parameter int LEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_byte,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             sck,
    output logic             ss,
    output logic             sdi,
    input  logic             sdo
);

    localparam int c_CNT_MAX = (HALF_DIV > GAP) ? HALF_DIV : GAP;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(HALF_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_LOAD  = 3'd3,
        S_END   = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic               r_phase;
    logic [7:0]         r_tx_sr;
    logic [LEN_W-1:0]   r_remain;
    logic               r_ss;
    logic               r_sck;
    logic               r_sdi;
    logic               r_done;
    logic               w_half_last;
    logic               w_gap_last;
    logic               w_sample;

    assign w_half_last = (r_cnt == c_HALF_LAST);
    assign w_gap_last  = (r_cnt == c_GAP_LAST);
    // sdo is captured on the same clk edge that drives sck high
    assign w_sample    = (r_state == S_SHIFT) && w_half_last && !r_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        tx_ready    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_half_last) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_half_last && r_phase && (r_bit == 3'd7)) begin
                    w_state_nxt = (r_remain != '0) ? S_LOAD : S_END;
                end
            end
            S_LOAD: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_END: begin
                if (w_half_last) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_bit    <= 3'd0;
            r_phase  <= 1'b0;
            r_tx_sr  <= 8'h00;
            r_remain <= '0;
            r_ss     <= 1'b1;
            r_sck    <= 1'b0;
            r_sdi    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_bit   <= 3'd0;
                    r_phase <= 1'b0;
                    if (cmd_valid) begin
                        r_tx_sr  <= cmd_byte;
                        r_remain <= cmd_len;
                        r_ss     <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (w_half_last) begin
                        r_cnt   <= '0;
                        r_sdi   <= r_tx_sr[7];
                        r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_half_last) begin
                        r_cnt <= '0;
                        if (!r_phase) begin
                            r_sck   <= 1'b1;
                            r_phase <= 1'b1;
                        end else begin
                            r_sck   <= 1'b0;
                            r_phase <= 1'b0;
                            if (r_bit == 3'd7) begin
                                r_bit <= 3'd0;
                            end else begin
                                // start of the next low phase: present the next bit
                                r_bit   <= r_bit + 3'd1;
                                r_sdi   <= r_tx_sr[7];
                                r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    r_cnt <= '0;
                    if (tx_valid) begin
                        r_sdi   <= tx_data[7];
                        r_tx_sr <= {tx_data[6:0], 1'b0};
                        if (r_remain != '0) begin
                            r_remain <= r_remain - LEN_W'(1);
                        end
                    end
                end
                S_END: begin
                    if (w_half_last) begin
                        r_cnt  <= '0;
                        r_ss   <= 1'b1;
                        r_sdi  <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_gap_last) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign ss   = r_ss;
    assign sck  = r_sck;
    assign sdi  = r_sdi;
    assign done = r_done;

`ifdef MIST_SPI_HOST_RX_EN
    logic [7:0] r_rx_sr;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_sr    <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_sample) begin
                r_rx_sr <= {r_rx_sr[6:0], sdo};
                if (r_bit == 3'd7) begin
                    r_rx_data  <= {r_rx_sr[6:0], sdo};
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
`else
    logic w_sdo_unused;
    logic w_sample_unused;

    assign w_sdo_unused    = sdo;
    assign w_sample_unused = w_sample;
    assign rx_data         = 8'h00;
    assign rx_valid        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mist_spi_host.sv
`default_nettype none
// tb_mist_spi_host: directed self-checking bench for mist_spi_host with a
// mode-0 slave model that records received bytes and returns a byte table.
module tb_mist_spi_host;
    localparam int HALF_DIV = 2;
    localparam int GAP      = 8;
    localparam int LEN_W    = 16;
    localparam int TMO      = 2000;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_byte  = 8'h00;
    logic [LEN_W-1:0] cmd_len   = '0;
    logic [7:0]       tx_data   = 8'h00;
    logic             tx_valid  = 1'b0;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;
    logic             sck;
    logic             ss;
    logic             sdi;
    logic             sdo;

    int tests_run    = 0;
    int tests_failed = 0;
    int stall_bad    = 0;

    mist_spi_host #(
        .HALF_DIV (HALF_DIV),
        .GAP      (GAP),
        .LEN_W    (LEN_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_byte  (cmd_byte),
        .cmd_len   (cmd_len),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .done      (done),
        .sck       (sck),
        .ss        (ss),
        .sdi       (sdi),
        .sdo       (sdo)
    );

    always #5 clk = ~clk;

    // Slave model: samples sdi on sck rise, resynchronises on ss high.
    logic [2:0] s_bits       = 3'd0;
    logic [2:0] s_fbyte      = 3'd0;
    logic [7:0] s_sr         = 8'h00;
    int         s_sck_total  = 0;
    int         s_byte_total = 0;
    logic [7:0] s_rx_bytes [256];
    logic [7:0] s_tx_tbl [8];
    logic [7:0] s_cur;

    always @(posedge sck or posedge ss) begin
        if (ss) begin
            s_bits  <= 3'd0;
            s_fbyte <= 3'd0;
        end else begin
            s_sr        <= {s_sr[6:0], sdi};
            s_sck_total <= s_sck_total + 1;
            s_bits      <= s_bits + 3'd1;
            if (s_bits == 3'd7) begin
                s_rx_bytes[s_byte_total[7:0]] <= {s_sr[6:0], sdi};
                s_byte_total <= s_byte_total + 1;
                s_fbyte      <= s_fbyte + 3'd1;
            end
        end
    end

    assign s_cur = s_tx_tbl[s_fbyte];
    assign sdo   = ss ? 1'b0 : s_cur[3'd7 - s_bits];

    // Monitor sampled on the inactive clock edge
    int         m_done     = 0;
    int         m_rxn      = 0;
    int         m_txr      = 0;
    int         m_low      = 0;
    int         m_last_low = 0;
    int         m_hi       = 0;
    int         m_last_hi  = 0;
    logic [7:0] m_rx [16];

    always @(negedge clk) begin
        if (done) m_done <= m_done + 1;
        if (rx_valid) begin
            m_rx[m_rxn[3:0]] <= rx_data;
            m_rxn <= m_rxn + 1;
        end
        if (tx_ready) m_txr <= m_txr + 1;
        if (!ss) begin
            m_low <= m_low + 1;
        end else begin
            if (m_low != 0) m_last_low <= m_low;
            m_low <= 0;
        end
        if (ss) begin
            m_hi <= m_hi + 1;
        end else begin
            if (m_hi != 0) m_last_hi <= m_hi;
            m_hi <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [LEN_W-1:0] len,
                              input logic [31:0] pl, input int stall_idx, input int stall_cyc);
        int k;
        k = 0;
        while (!cmd_ready && k < TMO) begin tick(); k++; end
        tests_run++;
        if (k >= TMO) begin
            tests_failed++;
            $display("FAIL cmd_ready_timeout: waited %0d cycles, required < %0d", k, TMO);
        end
        cmd_byte  = cmd;
        cmd_len   = len;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            if (i == stall_idx) begin
                tx_valid = 1'b0;
                k = 0;
                while (!tx_ready && k < TMO) begin tick(); k++; end
                for (int s = 0; s < stall_cyc; s++) begin
                    tick();
                    if (ss !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1) stall_bad++;
                end
            end
            tx_data  = pl[31-8*i -: 8];
            tx_valid = 1'b1;
            k = 0;
            while (!tx_ready && k < TMO) begin tick(); k++; end
            tick();
        end
        tx_valid = 1'b0;
        k = 0;
        while (!done && k < TMO) begin tick(); k++; end
        tests_run++;
        if (k >= TMO) begin
            tests_failed++;
            $display("FAIL done_timeout: waited %0d cycles, required < %0d", k, TMO);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        tests_run += 9;
        if (ss !== 1'b1)        begin tests_failed++; $display("FAIL reset_ss: got %b, expected 1", ss); end
        if (sck !== 1'b0)       begin tests_failed++; $display("FAIL reset_sck: got %b, expected 0", sck); end
        if (sdi !== 1'b0)       begin tests_failed++; $display("FAIL reset_sdi: got %b, expected 0", sdi); end
        if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b, expected 1", cmd_ready); end
        if (tx_ready !== 1'b0)  begin tests_failed++; $display("FAIL reset_tx_ready: got %b, expected 0", tx_ready); end
        if (rx_valid !== 1'b0)  begin tests_failed++; $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid); end
        if (rx_data !== 8'h00)  begin tests_failed++; $display("FAIL reset_rx_data: got %h, expected 00", rx_data); end
        if (busy !== 1'b0)      begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (done !== 1'b0)      begin tests_failed++; $display("FAIL reset_done: got %b, expected 0", done); end
    endtask

    task automatic test_set_control();
        int b_sck, b_byte, b_done;
        logic [31:0] word;
        b_sck = s_sck_total; b_byte = s_byte_total; b_done = m_done;
        send_frame(8'h04, 16'd4, 32'h12345678, -1, 0);
        word = {s_rx_bytes[8'(b_byte+1)], s_rx_bytes[8'(b_byte+2)],
                s_rx_bytes[8'(b_byte+3)], s_rx_bytes[8'(b_byte+4)]};
        tests_run += 5;
        if (s_sck_total - b_sck != 40) begin tests_failed++; $display("FAIL setctl_sck: got %0d pulses, expected 40", s_sck_total - b_sck); end
        if (s_rx_bytes[8'(b_byte)] !== 8'h04) begin tests_failed++; $display("FAIL setctl_cmd: got %h, expected 04", s_rx_bytes[8'(b_byte)]); end
        if (word !== 32'h12345678) begin tests_failed++; $display("FAIL setctl_ctrl_out: got %h, expected 12345678", word); end
        if (m_done - b_done != 1) begin tests_failed++; $display("FAIL setctl_done: got %0d pulses, expected 1", m_done - b_done); end
        if (m_last_low != 168) begin tests_failed++; $display("FAIL setctl_frame_len: got %0d cycles, expected 168", m_last_low); end
    endtask

    task automatic test_write_stall();
        int b_byte;
        logic [15:0] w0, w1;
        b_byte = s_byte_total;
        stall_bad = 0;
        send_frame(8'h02, 16'd4, 32'hAA550102, 2, 20);
        w0 = {s_rx_bytes[8'(b_byte+1)], s_rx_bytes[8'(b_byte+2)]};
        w1 = {s_rx_bytes[8'(b_byte+3)], s_rx_bytes[8'(b_byte+4)]};
        tests_run += 4;
        if (stall_bad != 0) begin tests_failed++; $display("FAIL stall_hold: got %0d bad cycles, expected 0", stall_bad); end
        if (w0 !== 16'hAA55) begin tests_failed++; $display("FAIL stall_word0: got %h, expected aa55", w0); end
        if (w1 !== 16'h0102) begin tests_failed++; $display("FAIL stall_word1: got %h, expected 0102", w1); end
        if (m_last_low != 188) begin tests_failed++; $display("FAIL stall_frame_len: got %0d cycles, expected 188", m_last_low); end
    endtask

    task automatic test_read_rx();
        int b_rx, b_byte;
        b_rx = m_rxn; b_byte = s_byte_total;
        s_tx_tbl[0] = 8'hC3; s_tx_tbl[1] = 8'hBE; s_tx_tbl[2] = 8'hEF;
        send_frame(8'h03, 16'd2, 32'h00000000, -1, 0);
        tests_run += 2;
        if (s_rx_bytes[8'(b_byte)] !== 8'h03) begin tests_failed++; $display("FAIL read_cmd: got %h, expected 03", s_rx_bytes[8'(b_byte)]); end
`ifdef MIST_SPI_HOST_RX_EN
        if (m_rxn - b_rx != 3) begin tests_failed++; $display("FAIL read_rx_count: got %0d, expected 3", m_rxn - b_rx); end
        tests_run += 3;
        if (m_rx[4'(b_rx)] !== 8'hC3)   begin tests_failed++; $display("FAIL read_rx0: got %h, expected c3", m_rx[4'(b_rx)]); end
        if (m_rx[4'(b_rx+1)] !== 8'hBE) begin tests_failed++; $display("FAIL read_rx1: got %h, expected be", m_rx[4'(b_rx+1)]); end
        if (m_rx[4'(b_rx+2)] !== 8'hEF) begin tests_failed++; $display("FAIL read_rx2: got %h, expected ef", m_rx[4'(b_rx+2)]); end
`else
        if (m_rxn - b_rx != 0) begin tests_failed++; $display("FAIL read_rx_count: got %0d, expected 0", m_rxn - b_rx); end
        tests_run++;
        if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL read_rx_data: got %h, expected 00", rx_data); end
`endif
        s_tx_tbl[0] = 8'h00; s_tx_tbl[1] = 8'h00; s_tx_tbl[2] = 8'h00;
    endtask

    task automatic test_cmd_only();
        int b_sck, b_byte, b_txr, b_done;
        b_sck = s_sck_total; b_byte = s_byte_total; b_txr = m_txr; b_done = m_done;
        send_frame(8'h0A, 16'd0, 32'h0, -1, 0);
        tests_run += 5;
        if (s_sck_total - b_sck != 8) begin tests_failed++; $display("FAIL nak_sck: got %0d pulses, expected 8", s_sck_total - b_sck); end
        if (s_rx_bytes[8'(b_byte)] !== 8'h0A) begin tests_failed++; $display("FAIL nak_cmd: got %h, expected 0a", s_rx_bytes[8'(b_byte)]); end
        if (m_txr - b_txr != 0) begin tests_failed++; $display("FAIL nak_tx_ready: got %0d cycles, expected 0", m_txr - b_txr); end
        if (m_done - b_done != 1) begin tests_failed++; $display("FAIL nak_done: got %0d pulses, expected 1", m_done - b_done); end
        if (m_last_low != 36) begin tests_failed++; $display("FAIL nak_frame_len: got %0d cycles, expected 36", m_last_low); end
    endtask

    task automatic test_back_to_back();
        int b_sck, b_byte, b_done, k;
        b_sck = s_sck_total; b_byte = s_byte_total; b_done = m_done;
        k = 0;
        while (!cmd_ready && k < TMO) begin tick(); k++; end
        cmd_byte  = 8'h01;
        cmd_len   = '0;
        cmd_valid = 1'b1;
        k = 0;
        while ((m_done - b_done) < 2 && k < TMO) begin tick(); k++; end
        cmd_valid = 1'b0;
        repeat (3) tick();
        tests_run += 5;
        if (m_done - b_done != 2) begin tests_failed++; $display("FAIL b2b_done: got %0d pulses, expected 2", m_done - b_done); end
        if (s_sck_total - b_sck != 16) begin tests_failed++; $display("FAIL b2b_sck: got %0d pulses, expected 16", s_sck_total - b_sck); end
        if (s_rx_bytes[8'(b_byte)] !== 8'h01) begin tests_failed++; $display("FAIL b2b_cmd0: got %h, expected 01", s_rx_bytes[8'(b_byte)]); end
        if (s_rx_bytes[8'(b_byte+1)] !== 8'h01) begin tests_failed++; $display("FAIL b2b_cmd1: got %h, expected 01", s_rx_bytes[8'(b_byte+1)]); end
        if (m_last_hi < GAP) begin tests_failed++; $display("FAIL b2b_gap: got %0d cycles, expected >= %0d", m_last_hi, GAP); end
    endtask

    task automatic test_reset_mid_frame();
        int b_sck, b_byte, k;
        logic sck_before;
        logic [31:0] word;
        b_sck = s_sck_total;
        k = 0;
        while (!cmd_ready && k < TMO) begin tick(); k++; end
        cmd_byte  = 8'h02;
        cmd_len   = 16'd4;
        cmd_valid = 1'b1;
        tx_data   = 8'hAA;
        tx_valid  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        k = 0;
        while ((s_sck_total - b_sck) < 13 && k < TMO) begin tick(); k++; end
        #2;
        sck_before = sck;
        reset_n = 1'b0;
        #1;
        tests_run += 4;
        if (sck_before !== 1'b1) begin tests_failed++; $display("FAIL abort_sck_before: got %b, expected 1", sck_before); end
        if (ss !== 1'b1)  begin tests_failed++; $display("FAIL abort_ss: got %b, expected 1", ss); end
        if (sck !== 1'b0) begin tests_failed++; $display("FAIL abort_sck: got %b, expected 0", sck); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b, expected 0", busy); end
        tx_valid = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        b_byte = s_byte_total;
        send_frame(8'h04, 16'd4, 32'h0000FFFF, -1, 0);
        word = {s_rx_bytes[8'(b_byte+1)], s_rx_bytes[8'(b_byte+2)],
                s_rx_bytes[8'(b_byte+3)], s_rx_bytes[8'(b_byte+4)]};
        tests_run += 2;
        if (s_rx_bytes[8'(b_byte)] !== 8'h04) begin tests_failed++; $display("FAIL resync_cmd: got %h, expected 04", s_rx_bytes[8'(b_byte)]); end
        if (word !== 32'h0000FFFF) begin tests_failed++; $display("FAIL resync_ctrl_out: got %h, expected 0000ffff", word); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) s_tx_tbl[i] = 8'h00;
        test_reset();
        test_set_control();
        test_write_stall();
        test_read_rx();
        test_cmd_only();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mist_spi_host.md
# mist_spi_host

SPI master that drives the MiST IO-controller link (`sck`, `ss`, `sdi`, `sdo`) from the FPGA system clock domain. It is the initiator end of the command protocol whose FPGA-side responder already decodes commands such as SET_ADDRESS 0x01, WRITE_MEMORY 0x02, READ_MEMORY 0x03, SET_CONTROL 0x04 and NAK_DMA 0x0a. It serves two purposes: on-chip self-loading, where a local boot sequencer replays ROM and config uploads without the ARM, and a synthesizable stimulus source for core-level benches. The block frames one command byte plus N payload bytes per `ss` assertion, streams payload in, and optionally returns the bytes shifted out on `sdo`.

## Interface

Parameters:
- `HALF_DIV`, default 2: `clk` cycles per SCK half-period. Minimum 1.
- `GAP`, default 8: minimum `clk` cycles `ss` stays high between frames. Minimum 4.
- `LEN_W`, default 16: width of the payload length field.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: start-frame request.
- `cmd_ready` out 1: high in IDLE only.
- `cmd_byte` in 8: command opcode.
- `cmd_len` in LEN_W: number of payload bytes, 0..2^LEN_W−1.
- `tx_data` in 8: next payload byte.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: the block accepts `tx_data` this cycle.
- `rx_data` out 8: byte sampled from `sdo`.
- `rx_valid` out 1: one-cycle pulse when `rx_data` is updated.
- `busy` out 1: a frame or the inter-frame gap is in progress.
- `done` out 1: one-cycle pulse when `ss` rises at the end of a frame.
- `sck` out 1: SPI clock, idles low.
- `ss` out 1: select, active-low, idles high.
- `sdi` out 1: master-to-slave data.
- `sdo` in 1: slave-to-master data.

## Operation

- Reset values: `ss`=1, `sck`=0, `sdi`=0, `cmd_ready`=1, `tx_ready`=0, `rx_valid`=0, `rx_data`=0x00, `busy`=0, `done`=0, state IDLE.
- States and transitions:
  - IDLE: on `cmd_valid & cmd_ready`, latch `cmd_byte` and `cmd_len` into the shift register and `remain`, drop `ss`, and go to SETUP.
  - SETUP: wait `HALF_DIV` cycles, then go to SHIFT.
  - SHIFT: send 8 bits, MSB first. When the byte ends, go to LOAD if `remain`≠0, otherwise go to END.
  - LOAD: assert `tx_ready`. On `tx_valid`, load `tx_data`, decrement `remain`, and go to SHIFT. While `tx_valid` is low, hold `sck` low and keep `ss` low. Stalls of any length are legal.
  - END: wait `HALF_DIV` cycles with `sck` low, raise `ss`, pulse `done`, and go to GAP.
  - GAP: count `GAP` cycles, then go to IDLE.
- `busy` is high in every state except IDLE.
- `cmd_len`=0 produces a command-only frame: exactly 8 SCK pulses.
- Bit cell:
  - `sdi` is updated at the start of the low phase.
  - `sck` stays low for `HALF_DIV` cycles, then high for `HALF_DIV` cycles.
  - `sdo` is sampled on the `clk` edge where `sck` rises and shifted into the rx shift register, MSB first.
- After the 8th sample, `rx_data` takes the assembled byte and `rx_valid` pulses on the next cycle. This happens once per byte, including the command byte.
- The byte counter is LEN_W bits wide and never wraps. `remain` is only decremented when it is nonzero.
- Reset asserted mid-frame forces `ss` high and `sck` low immediately, asynchronously. A partial frame is discarded and the slave resynchronizes on `ss` high.
- `cmd_valid` asserted outside IDLE is ignored until `cmd_ready` is high.

## Timing

- Frame length: `HALF_DIV` + 16·`HALF_DIV`·(1+`cmd_len`) + `HALF_DIV` cycles, plus any LOAD stall cycles.
- LOAD with `tx_valid` already high costs exactly 1 extra cycle per payload byte, with `sck` low.
- `cmd_ready` is low from the cycle after acceptance until GAP completes. The minimum frame-to-frame spacing with `ss` high is `GAP` cycles; this covers the slave's two-flop end-of-transfer synchronizer.
- `done` rises in the same cycle that `ss` goes high.

## Configuration

- `MIST_SPI_HOST_RX_EN` defined: the `sdo` sampling and shift register are built, and `rx_data`/`rx_valid` behave as described above.
- `MIST_SPI_HOST_RX_EN` undefined: `sdo` is unused, `rx_data` is tied to 0x00 and `rx_valid` is tied to 0. Transmit timing is identical in both builds.

## Test plan

- SET_CONTROL: cmd 0x04, len 4, payload 12 34 56 78, responder model attached -> `ctrl_out`=0x12345678, 40 SCK pulses, one `done`.
- WRITE_MEMORY with stall: cmd 0x02, len 4, payload AA 55 01 02, `tx_valid` withheld 20 cycles before byte 3 -> `sck` low and `ss` low throughout the stall, data words 0xAA55 then 0x0102.
- READ_MEMORY readback (RX_EN): cmd 0x03, len 2, `data_out_reg`=0xBEEF -> 3 `rx_valid` pulses with `rx_data` matching the slave's shifted bits.
- Command-only frame: cmd 0x0a, len 0 -> 8 SCK pulses, `dma_nak` toggles once, `tx_ready` never asserted.
- Back-to-back frames: two SET_ADDRESS 0x01 frames, `cmd_valid` held high -> `ss` high for ≥`GAP` cycles between them, two `addr_strobe` toggles.
- Reset mid-frame: `reset_n` low after the 13th SCK of a WRITE_MEMORY frame -> `ss`=1 and `sck`=0 in the same cycle. The following SET_CONTROL 0x0000FFFF is then received correctly.
